// File: rtl/sub16_pkg.sv
// Shared types and cell primitives for the 16-bit pipelined subtractor.
// Kogge-Stone black/gray cells live here so adder and subtractor agree.
package sub16_pkg;

    localparam int SUB_W    = 16;
    localparam int SUB_LVLS = 4;

    // Stage-1 bundle: propagate/generate plus what the flags need later
    typedef struct packed {
        logic [SUB_W-1:0] p;
        logic [SUB_W-1:0] g;
        logic             cin;
        logic             sdiff;
        logic             a_msb;
    } s1_t;

    // Black cell returns {G, P} of the merged group
    function automatic logic [1:0] black_cell(
        input logic gik,
        input logic pik,
        input logic gk1j,
        input logic pk1j
    );
        return {gik | (pik & gk1j), pik & pk1j};
    endfunction

    // Gray cell: lower group already resolved, only G matters
    function automatic logic gray_cell(
        input logic gik,
        input logic pik,
        input logic gk1j
    );
        return gik | (pik & gk1j);
    endfunction

endpackage

// File: rtl/ks16_prefix.sv
// Four-level Kogge-Stone carry network with carry-in at position -1.
// Position 0 of the internal vectors holds cin; position k+1 holds bit k.
module ks16_prefix
    import sub16_pkg::*;
(
    input  logic [SUB_W-1:0] p_i,
    input  logic [SUB_W-1:0] g_i,
    input  logic             cin_i,
    output logic [SUB_W-1:0] c_o,
    output logic             cout_o
);

    logic [SUB_W-1:0] gl;
    logic [SUB_W-1:0] pl;
    logic [SUB_W-1:0] gn;
    logic [SUB_W-1:0] pn;

    // Prefix levels with span 1,2,4,8; gray cells once the group reaches cin
    always_comb begin
        gl = {g_i[SUB_W-2:0], cin_i};
        pl = {p_i[SUB_W-2:0], 1'b0};
        gn = gl;
        pn = pl;
        for (int l = 0; l < SUB_LVLS; l++) begin
            gn = gl;
            pn = pl;
            for (int j = 1; j < SUB_W; j++) begin
                if (j >= (1 << l)) begin
                    if (j < (2 << l)) begin
                        gn[j] = gray_cell(gl[j], pl[j], gl[j-(1<<l)]);
                    end else begin
                        {gn[j], pn[j]} = black_cell(gl[j], pl[j],
                                                    gl[j-(1<<l)],
                                                    pl[j-(1<<l)]);
                    end
                end
            end
            gl = gn;
            pl = pn;
        end
    end

    assign c_o    = gl;
    assign cout_o = g_i[SUB_W-1] | (p_i[SUB_W-1] & gl[SUB_W-1]);

endmodule

// File: rtl/sub16_pipe.sv
// Two-stage a - b - bin with valid/ready on both sides.
// Subtraction is a + ~b + ~bin through the Kogge-Stone prefix network.
module sub16_pipe
    import sub16_pkg::*;
#(
    parameter int W = SUB_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout,
    output logic         zero,
    output logic         ovf
);

    s1_t          s1_d;
    s1_t          s1_q;
    logic         v1_q;
    logic         v2_q;
    logic [W-1:0] c;
    logic         cout;
    logic         s2_en;
    logic [W-1:0] diff_d;
    logic [W-1:0] diff_q;
    logic         bout_d;
    logic         bout_q;
    logic         zero_d;
    logic         zero_q;
    logic         ovf_d;
    logic         ovf_q;

    assign s2_en    = ~v2_q | out_ready;
    assign in_ready = ~v1_q | s2_en;

    // PG generation on the inverted subtrahend
    always_comb begin
        s1_d       = '0;
        s1_d.p     = a ^ ~b;
        s1_d.g     = a & ~b;
        s1_d.cin   = ~bin;
        s1_d.sdiff = a[W-1] ^ b[W-1];
        s1_d.a_msb = a[W-1];
    end

    ks16_prefix u_prefix (
        .p_i    (s1_q.p),
        .g_i    (s1_q.g),
        .cin_i  (s1_q.cin),
        .c_o    (c),
        .cout_o (cout)
    );

    // Sum and flags from the stage-1 contents
    always_comb begin
        diff_d = s1_q.p ^ c;
        bout_d = ~cout;
        zero_d = ~|diff_d;
        ovf_d  = s1_q.sdiff & (diff_d[W-1] ^ s1_q.a_msb);
    end

    // Pipeline registers; data only moves with a valid beat
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            s1_q   <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            if (s2_en) begin
                v2_q <= v1_q;
            end
            if (s2_en && v1_q) begin
                diff_q <= diff_d;
                bout_q <= bout_d;
                zero_q <= zero_d;
                ovf_q  <= ovf_d;
            end
            if (in_ready) begin
                v1_q <= in_valid;
            end
            if (in_ready && in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    assign out_valid = v2_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_sub16_pipe.sv
// Directed and randomized checks for sub16_pipe.
// Expected values come from hand tables and an integer reference model.
module tb_sub16_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;

    int checks;
    int failures;

    sub16_pipe #(.W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, diff, bout, zero, ovf} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b d=%h b=%b z=%b o=%b want all 0",
                     out_valid, diff, bout, zero, ovf);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic;
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic        vc [5];
        logic [18:0] ve [5];
        va = '{16'h0005, 16'h0003, 16'h8000, 16'h0000, 16'h1234};
        vb = '{16'h0003, 16'h0005, 16'h0001, 16'hFFFF, 16'h1233};
        vc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        // {diff, bout, zero, ovf}
        ve = '{{16'h0002, 3'b000}, {16'hFFFE, 3'b100},
               {16'h7FFF, 3'b001}, {16'h0000, 3'b110},
               {16'h0000, 3'b010}};
        for (int i = 0; i < 5; i++) begin
            out_ready = 1'b1;
            in_valid = 1'b1;
            a = va[i];
            b = vb[i];
            bin = vc[i];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL basic%0d_accept: in_ready=%b want 1", i, in_ready);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a = 16'hDEAD;
            b = 16'hBEEF;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL basic%0d_early: out_valid=%b want 0", i, out_valid);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || {diff, bout, zero, ovf} !== ve[i]) begin
                failures++;
                $display("FAIL basic%0d_result: v=%b d=%h b=%b z=%b o=%b want v=1 %h",
                         i, out_valid, diff, bout, zero, ovf, ve[i]);
            end
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL basic%0d_drop: out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    // Beat k: a = k*0x111, b = k, bin = 0 -> diff = k*0x110
    task automatic test_back_to_back;
        out_ready = 1'b0;
        in_valid = 1'b1;
        bin = 1'b0;
        a = 16'h0111;
        b = 16'h0001;
        @(posedge clk);
        #1;
        a = 16'h0222;
        b = 16'h0002;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_second_accept: in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        a = 16'h0333;
        b = 16'h0003;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || diff !== 16'h0110) begin
                failures++;
                $display("FAIL bp_hold%0d: rdy=%b v=%b d=%h want rdy=0 v=1 d=0110",
                         c, in_ready, out_valid, diff);
            end
            if (c < 3) begin
                @(posedge clk);
                #1;
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready: in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        a = 16'h0444;
        b = 16'h0004;
        checks++;
        if (out_valid !== 1'b1 || diff !== 16'h0220 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_beat2: v=%b d=%h rdy=%b want v=1 d=0220 rdy=1",
                     out_valid, diff, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || diff !== 16'h0330) begin
            failures++;
            $display("FAIL bp_beat3: v=%b d=%h want v=1 d=0330", out_valid, diff);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || diff !== 16'h0440) begin
            failures++;
            $display("FAIL bp_beat4: v=%b d=%h want v=1 d=0440", out_valid, diff);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 16'h8000;
        b = 16'h0001;
        bin = 1'b0;
        @(posedge clk);
        #1;
        a = 16'h0000;
        b = 16'h0001;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || ovf !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_full: v=%b o=%b rdy=%b want v=1 o=1 rdy=0",
                     out_valid, ovf, in_ready);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({out_valid, diff, bout, zero, ovf} !== 20'h0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: v=%b d=%h b=%b z=%b o=%b rdy=%b want 0s rdy=1",
                     out_valid, diff, bout, zero, ovf, in_ready);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL mid_stale%0d: out_valid=%b want 0", c, out_valid);
            end
        end
    endtask

    task automatic test_random;
        localparam int NB = 10000;
        logic [15:0] sa [NB];
        logic [15:0] sb [NB];
        logic        sc [NB];
        logic [15:0] sw [5];
        logic [18:0] exp_q [$];
        logic [18:0] e;
        logic [16:0] full;
        int          s;
        int          idx;
        int          cyc;
        int          n;
        sw = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
        n = 0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                for (int k = 0; k < 2; k++) begin
                    sa[n] = sw[i];
                    sb[n] = sw[j];
                    sc[n] = k[0];
                    n++;
                end
        for (int i = n; i < NB; i++) begin
            sa[i] = 16'($urandom);
            sb[i] = 16'($urandom);
            sc[i] = 1'($urandom);
        end
        idx = 0;
        cyc = 0;
        while ((idx < NB || exp_q.size() != 0) && cyc < 60000) begin
            @(posedge clk);
            #1;
            in_valid = (idx < NB) && ($urandom_range(3) != 0);
            if (idx < NB) begin
                a = sa[idx];
                b = sb[idx];
                bin = sc[idx];
            end
            out_ready = (idx >= NB) || ($urandom_range(3) != 0);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_spurious: d=%h with no beat pending", diff);
                end else begin
                    e = exp_q.pop_front();
                    if ({diff, bout, zero, ovf} !== e) begin
                        failures++;
                        $display("FAIL rand_beat: got d=%h b=%b z=%b o=%b want %h",
                                 diff, bout, zero, ovf, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                full = {1'b0, a} - {1'b0, b} - {16'h0, bin};
                s = int'($signed(a)) - int'($signed(b)) - int'(bin);
                exp_q.push_back({full[15:0], full[16], full[15:0] == 16'h0,
                                 (s > 32767) || (s < -32768)});
                idx++;
            end
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != NB || exp_q.size() != 0) begin
            failures++;
            $display("FAIL rand_drain: sent=%0d pending=%0d want sent=%0d pending=0",
                     idx, exp_q.size(), NB);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_reset_midstream;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
